// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one single-access SDRAM request/response bus among NPORT
// requesters; one transaction in flight, read responses routed back to the issuing port.
module sdram_arbiter #(
  parameter int unsigned NPORT    = 2,
  parameter int unsigned AVS_DW   = 16,
  parameter int unsigned AVS_AW   = 25,
  parameter int unsigned AVS_BYTE = AVS_DW / 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NPORT-1:0]          port_req_valid,
  input  logic [NPORT-1:0]          port_req_write,
  input  logic [NPORT*AVS_AW-1:0]   port_req_address,
  input  logic [NPORT*AVS_DW-1:0]   port_req_writedata,
  input  logic [NPORT*AVS_BYTE-1:0] port_req_byteenable,
  output logic [NPORT-1:0]          port_req_ready,
  output logic [NPORT-1:0]          port_resp_valid,
  output logic [AVS_DW-1:0]         port_resp_readdata,
  output logic                      bus_req_valid,
  output logic                      bus_req_write,
  output logic [AVS_AW-1:0]         bus_req_address,
  output logic [AVS_DW-1:0]         bus_req_writedata,
  output logic [AVS_BYTE-1:0]       bus_req_byteenable,
  input  logic                      bus_req_ready,
  input  logic                      bus_resp_valid,
  input  logic [AVS_DW-1:0]         bus_resp_readdata
);

  localparam int unsigned GW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] winner;
  logic          found;

  logic [GW-1:0]       cand     [NPORT];
  logic [AVS_AW-1:0]   addr_arr [NPORT];
  logic [AVS_DW-1:0]   data_arr [NPORT];
  logic [AVS_BYTE-1:0] be_arr   [NPORT];

  for (genvar i = 0; i < NPORT; i++) begin : g_unpack
    assign addr_arr[i] = port_req_address[i*AVS_AW +: AVS_AW];
    assign data_arr[i] = port_req_writedata[i*AVS_DW +: AVS_DW];
    assign be_arr[i]   = port_req_byteenable[i*AVS_BYTE +: AVS_BYTE];
  end

  // Candidate k is the port k+1 places after the last one served, so priority rotates.
  always_comb begin
    for (int unsigned k = 0; k < NPORT; k++) begin
      cand[k] = GW'((32'(last_q) + k + 32'd1) % NPORT);
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (!found && port_req_valid[cand[k]]) begin
        found  = 1'b1;
        winner = cand[k];
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    last_d             = last_q;
    bus_req_valid      = 1'b0;
    bus_req_write      = 1'b0;
    bus_req_address    = '0;
    bus_req_writedata  = '0;
    bus_req_byteenable = '0;
    port_req_ready     = '0;
    port_resp_valid    = '0;
    port_resp_readdata = bus_resp_readdata;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = winner;
          state_d = StIssue;
        end
      end
      StIssue: begin
        bus_req_valid           = port_req_valid[grant_q];
        bus_req_write           = port_req_write[grant_q];
        bus_req_address         = addr_arr[grant_q];
        bus_req_writedata       = data_arr[grant_q];
        bus_req_byteenable      = be_arr[grant_q];
        port_req_ready[grant_q] = bus_req_ready;
        if (!port_req_valid[grant_q]) begin
          // Requester withdrew before acceptance: priority pointer stays put.
          state_d = StIdle;
        end else if (bus_req_ready) begin
          last_d  = grant_q;
          state_d = port_req_write[grant_q] ? StIdle : StResp;
        end
      end
      StResp: begin
        port_resp_valid[grant_q] = bus_resp_valid;
        if (bus_resp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GW'(NPORT - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
